// File: rtl/pong_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_pkg : shared game states, serve position and paddle helper      |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SCORE = 2'd2,
        ST_OVER  = 2'd3
    } pong_state_e;

    localparam logic [2:0] BALL_X0       = 3'd3;
    localparam logic [2:0] BALL_Y0       = 3'd3;
    localparam logic [2:0] PADDLE_HIDDEN = 3'd7;

    // A visible paddle at column p occupies columns p and p+1.
    function automatic logic paddle_covers(input logic [2:0] paddle, input logic [2:0] col);
        return (paddle != PADDLE_HIDDEN) && ((col == paddle) || (col == paddle + 3'd1));
    endfunction

endpackage
`default_nettype wire

// File: rtl/pong_step_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_step_timer : programmable step divider with clear and enable    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pong_step_timer #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    logic [CNT_W-1:0] count_q;

    // >= keeps the divider safe if the period shrinks below the running count.
    assign tick_o = enable_i && (count_q >= period_i - C_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i || !enable_i || tick_o) begin
            count_q <= '0;
        end else begin
            count_q <= count_q + C_ONE;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pong_ball_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pong_ball_controller : ball motion, paddle collision, scoring, FSM   |
// | Option   : PONG_SPEEDUP_EN shortens the step period on paddle hits   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module pong_ball_controller
    import pong_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int BIT_OF_WIDTH = 3,
    parameter int TICK_DIV     = 1000000,
    parameter int SCORE_MAX    = 9,
    parameter int SCORE_HOLD   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2:0]              player_top,
    input  logic [2:0]              player_down,
    output logic [BIT_OF_WIDTH-1:0] x_pos,
    output logic [BIT_OF_WIDTH-1:0] y_pos,
    output logic [3:0]              score_top,
    output logic [3:0]              score_down,
    output logic [1:0]              game_state,
    output logic                    game_over
);

    localparam int CNT_W  = $clog2(TICK_DIV + 1);
    localparam int HOLD_W = $clog2(SCORE_HOLD + 1);

    localparam logic [BIT_OF_WIDTH-1:0] C_ZERO = '0;
    localparam logic [BIT_OF_WIDTH-1:0] C_ONE  = BIT_OF_WIDTH'(1);
    localparam logic [BIT_OF_WIDTH-1:0] C_TWO  = BIT_OF_WIDTH'(2);
    localparam logic [BIT_OF_WIDTH-1:0] C_NEAR = BIT_OF_WIDTH'(WIDTH - 3);
    localparam logic [BIT_OF_WIDTH-1:0] C_EDGE = BIT_OF_WIDTH'(WIDTH - 2);
    localparam logic [BIT_OF_WIDTH-1:0] C_MAX  = BIT_OF_WIDTH'(WIDTH - 1);
    localparam logic [3:0]              C_SMAX = 4'(SCORE_MAX);
    localparam logic [HOLD_W-1:0]       C_HOLD_LAST = HOLD_W'(SCORE_HOLD - 1);
    localparam logic [HOLD_W-1:0]       C_HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]        PERIOD_FULL = CNT_W'(TICK_DIV);

    pong_state_e             state_q, state_d;
    logic [BIT_OF_WIDTH-1:0] x_q, x_d, y_q, y_d, xn;
    logic                    dx_q, dx_d, dy_q, dy_d, dxn;
    logic [3:0]              st_q, st_d, sd_q, sd_d;
    logic [HOLD_W-1:0]       hold_q, hold_d;
    logic                    game_over_q, game_over_d;
    logic                    w_restart, w_tick;
    logic [CNT_W-1:0]        w_period;

`ifdef PONG_SPEEDUP_EN
    localparam logic [CNT_W-1:0] PERIOD_STEP = CNT_W'(TICK_DIV / 8);
    localparam logic [CNT_W-1:0] PERIOD_MIN  = CNT_W'(TICK_DIV / 4);
    logic [CNT_W-1:0] period_q, period_d;
    assign w_period = period_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) period_q <= PERIOD_FULL;
        else        period_q <= period_d;
    end
`else
    assign w_period = PERIOD_FULL;
`endif

    pong_step_timer #(.CNT_W(CNT_W)) u_step_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (w_restart),
        .enable_i ((state_q == ST_PLAY) || (state_q == ST_SCORE)),
        .period_i (w_period),
        .tick_o   (w_tick)
    );

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dx_d      = dx_q;
        dy_d      = dy_q;
        st_d      = st_q;
        sd_d      = sd_q;
        hold_d    = hold_q;
        w_restart = 1'b0;
`ifdef PONG_SPEEDUP_EN
        period_d  = period_q;
`endif
        // Horizontal move is resolved first; the paddle test uses its result.
        if (dx_q && (x_q == C_MAX)) begin
            xn = C_EDGE; dxn = 1'b0;
        end else if (!dx_q && (x_q == C_ZERO)) begin
            xn = C_ONE;  dxn = 1'b1;
        end else begin
            xn = dx_q ? x_q + C_ONE : x_q - C_ONE; dxn = dx_q;
        end

        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    w_restart = 1'b1;
                    state_d   = ST_PLAY;
                    x_d = BALL_X0; y_d = BALL_Y0; dx_d = 1'b1; dy_d = 1'b1;
                    st_d = '0; sd_d = '0; hold_d = '0;
`ifdef PONG_SPEEDUP_EN
                    period_d = PERIOD_FULL;
`endif
                end
            end
            ST_PLAY: begin
                if (w_tick) begin
                    x_d  = xn;
                    dx_d = dxn;
                    if (dy_q && (y_q == C_EDGE)) begin
                        if (paddle_covers(player_down, xn)) begin
                            dy_d = 1'b0; y_d = C_NEAR;
`ifdef PONG_SPEEDUP_EN
                            period_d = (period_q >= PERIOD_MIN + PERIOD_STEP) ?
                                       period_q - PERIOD_STEP : PERIOD_MIN;
`endif
                        end else begin
                            y_d = C_MAX; state_d = ST_SCORE; hold_d = '0;
                            st_d = (st_q == C_SMAX) ? st_q : st_q + 4'd1;
                        end
                    end else if (!dy_q && (y_q == C_ONE)) begin
                        if (paddle_covers(player_top, xn)) begin
                            dy_d = 1'b1; y_d = C_TWO;
`ifdef PONG_SPEEDUP_EN
                            period_d = (period_q >= PERIOD_MIN + PERIOD_STEP) ?
                                       period_q - PERIOD_STEP : PERIOD_MIN;
`endif
                        end else begin
                            y_d = C_ZERO; state_d = ST_SCORE; hold_d = '0;
                            sd_d = (sd_q == C_SMAX) ? sd_q : sd_q + 4'd1;
                        end
                    end else begin
                        y_d = dy_q ? y_q + C_ONE : y_q - C_ONE;
                    end
                end
            end
            ST_SCORE: begin
                if (w_tick) begin
                    if (hold_q == C_HOLD_LAST) begin
                        hold_d = '0;
                        if ((st_q == C_SMAX) || (sd_q == C_SMAX)) begin
                            state_d = ST_OVER;
                        end else begin
                            // Serve toward whoever let the ball through.
                            state_d = ST_PLAY;
                            x_d = BALL_X0; y_d = BALL_Y0;
                            dy_d = (y_q == C_MAX);
`ifdef PONG_SPEEDUP_EN
                            period_d = PERIOD_FULL;
`endif
                        end
                    end else begin
                        hold_d = hold_q + C_HOLD_ONE;
                    end
                end
            end
            default: ;
        endcase
        game_over_d = (state_d == ST_OVER);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            x_q         <= BALL_X0;
            y_q         <= BALL_Y0;
            dx_q        <= 1'b1;
            dy_q        <= 1'b1;
            st_q        <= '0;
            sd_q        <= '0;
            hold_q      <= '0;
            game_over_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dx_q        <= dx_d;
            dy_q        <= dy_d;
            st_q        <= st_d;
            sd_q        <= sd_d;
            hold_q      <= hold_d;
            game_over_q <= game_over_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign score_top  = st_q;
    assign score_down = sd_q;
    assign game_state = state_q;
    assign game_over  = game_over_q;

endmodule
`default_nettype wire
